ref_gen_array: RTL and testbench
================================

# ref_gen_array

Parametrised multi-channel reference-clock generator for the ADPLL array test builds. It produces CHANNELS square-wave reference outputs from the 100 MHz system clock, each with its own runtime-programmable half-period and phase offset. It supports free-run, phase-aligned and burst modes, so the on-board ADPLL arrays can be driven without an external reference. It sits between the switch/config decode logic and the ADPLL reference inputs (ra_i) of each array element.

## Interface

- CHANNELS, 4: number of reference outputs (≥1).
- CNT_W, 12: width of the half-period and phase fields.
- DEFAULT_HALF, 20: half-period loaded at reset, in clk100_i cycles.
- BURST_EDGES, 8: rising edges of channel 0 emitted in burst mode (≥1).

- clk100_i  in  1  system clock, 100 MHz.
- rst_pbn_i  in  1  asynchronous, active-low reset.
- mode_i  in  2  00 stop, 01 free-run, 10 aligned-run, 11 burst.
- cfg_valid_i  in  1  config write request.
- cfg_ready_o  out  1  config write accepted when valid & ready.
- cfg_chan_i  in  max(1,$clog2(CHANNELS))  target channel; values ≥ CHANNELS are ignored but still handshake.
- cfg_half_i  in  CNT_W  new half-period H; 0 is stored as 1.
- cfg_phase_i  in  CNT_W  new phase offset P, in cycles.
- ref_o  out  CHANNELS  reference square waves, registered.
- sync_o  out  1  one-cycle pulse coincident with each rising edge of ref_o[0].
- busy_o  out  1  FSM not in IDLE.

## Operation

- Per-channel state: active H and P, pending H and P, pend flag, down-counter, delay counter.
- Reset values: ref_o=0, sync_o=0, busy_o=0, all pend=0, H=DEFAULT_HALF, P=0, FSM=IDLE.
- cfg_ready_o = ~pend[cfg_chan_i] (combinational); it is 1 for out-of-range channels. An accepted write stores the pending values and sets pend.
- Pending values are applied as follows:
  - IDLE or DONE: on the next edge.
  - ALIGN: at the ALIGN edge.
  - RUN: on the edge where that channel's output falls (high→low). The new period therefore always starts with a low half.
  - Applying clears pend.
- FSM states: IDLE, ALIGN, RUN, DONE.
  - IDLE: all outputs low, counters cleared. mode 01 → RUN with all channels rising at that same edge, P ignored. mode 10 or 11 → ALIGN.
  - ALIGN: one cycle, outputs low. Each channel's delay counter is loaded with P. Next state is RUN.
  - RUN:
    - A channel waits out its delay with output low, then rises.
    - Each output toggles every H edges, giving period 2H.
    - mode 00 → IDLE, with ref_o=0 at that edge.
    - A 01→10 transition → ALIGN (realign).
    - A 10→01 transition continues without a glitch.
    - A change from 01/10 to 11 → ALIGN; the burst count restarts.
    - In mode 11, the edge producing the BURST_EDGES-th falling edge of ref_o[0] → DONE.
  - DONE: all ref_o=0. Stays in DONE while mode_i≠00; mode 00 → IDLE.
- The burst counter is cleared on entry to ALIGN. A change from 11 to 01 or 10 during RUN exits burst tracking: 10 → ALIGN, 01 → continue free-run.

## Timing

- mode_i is sampled every edge, and there is no input synchroniser; the upstream decode is already in the clk100_i domain.
- Free-run: ref_o[i] rises on the first edge that samples mode_i=01 in IDLE. Each half lasts exactly H cycles.
- Aligned: with E = the edge entering ALIGN, channel i first rises at edge E+1+P_i.
- sync_o is registered together with ref_o[0] and is high for exactly the cycle after ref_o[0] rises.
- H change in RUN: the old H holds through the current high half. The low half following the fall uses the new H.
- Asynchronous reset mid-operation clears all outputs and config immediately, with no clock needed. Operation after release starts in IDLE.
- Simultaneous write and apply on the same channel cannot occur: ready is low while pend is set.

## Test plan

- Reset/free-run (CHANNELS=4, DEFAULT_HALF=20): hold rst_pbn_i low → ref_o=0, busy_o=0, cfg_ready_o=1. Release, then mode 01 → all four outputs rise together, period 40 cycles, sync_o every 40 cycles.
- Runtime reconfig: while running, write ch2 H=5 → cfg_ready_o low for ch2 until ref_o[2]'s next fall. The next low half is 5 cycles, then period 10. Other channels are unaffected.
- Aligned phases: set P=0,3,7,12, then mode 10 → first rises at E+1, E+4, E+8, E+13. Afterwards 01 → no glitch; back to 10 → realign.
- Burst (BURST_EDGES=3, H=4): mode 11 → exactly 3 pulses on ref_o[0] and 3 sync_o pulses. Then all ref_o=0 with busy_o=1 until mode 00, after which busy_o=0.
- Edge values: write H=0 → period 2. Write to cfg_chan_i=5 → handshake completes and no channel changes.
- Async reset mid-burst: assert rst_pbn_i between clock edges → ref_o, sync_o and busy_o are 0 immediately, and H returns to 20.

Source files
------------

// File: rtl/ref_gen_array.sv
// rtl/ref_gen_array.sv - multi-channel reference clock generator with free-run, aligned and burst modes
// Each channel toggles every H cycles after an optional P-cycle delay; config writes are staged as pending.
module ref_gen_array #(
  parameter int CHANNELS     = 4,
  parameter int CNT_W        = 12,
  parameter int DEFAULT_HALF = 20,
  parameter int BURST_EDGES  = 8,
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int BC_W = $clog2(BURST_EDGES + 1)
) (
  input  logic                clk100_i,
  input  logic                rst_pbn_i,
  input  logic [1:0]          mode_i,
  input  logic                cfg_valid_i,
  output logic                cfg_ready_o,
  input  logic [CH_W-1:0]     cfg_chan_i,
  input  logic [CNT_W-1:0]    cfg_half_i,
  input  logic [CNT_W-1:0]    cfg_phase_i,
  output logic [CHANNELS-1:0] ref_o,
  output logic                sync_o,
  output logic                busy_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ALIGN = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]          r_state;
  logic [1:0]          r_mode_q;
  logic [CHANNELS-1:0] r_ref;
  logic                r_sync;
  logic [BC_W-1:0]     r_burst;
  logic [CHANNELS-1:0] r_pend;
  logic [CNT_W-1:0]    r_h      [CHANNELS];
  logic [CNT_W-1:0]    r_p      [CHANNELS];
  logic [CNT_W-1:0]    r_pend_h [CHANNELS];
  logic [CNT_W-1:0]    r_pend_p [CHANNELS];
  logic [CNT_W-1:0]    r_cnt    [CHANNELS];
  logic [CNT_W-1:0]    r_dly    [CHANNELS];

  logic [1:0]          w_state_nxt;
  logic [CHANNELS-1:0] w_ref_nxt;
  logic [BC_W-1:0]     w_burst_nxt;
  logic [CHANNELS-1:0] w_apply;
  logic                w_fall0;
  logic                w_realign;
  logic                w_ready;
  logic                w_wr;
  logic [CNT_W-1:0]    w_half_in;
  logic [CNT_W-1:0]    w_h_eff   [CHANNELS];
  logic [CNT_W-1:0]    w_p_eff   [CHANNELS];
  logic [CNT_W-1:0]    w_cnt_nxt [CHANNELS];
  logic [CNT_W-1:0]    w_dly_nxt [CHANNELS];

  always_comb begin
    w_ready = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg_chan_i == CH_W'(i)) w_ready = ~r_pend[i];
    end
  end

  assign w_wr      = cfg_valid_i & w_ready;
  assign w_half_in = (cfg_half_i == '0) ? CNT_W'(1) : cfg_half_i;

  // Values a channel will run with once its pending write is applied this edge
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      w_h_eff[i] = r_pend[i] ? r_pend_h[i] : r_h[i];
      w_p_eff[i] = r_pend[i] ? r_pend_p[i] : r_p[i];
    end
  end

  assign w_realign = ((mode_i == 2'b10) && (r_mode_q != 2'b10)) ||
                     ((mode_i == 2'b11) && (r_mode_q != 2'b11));

  always_comb begin
    w_state_nxt = r_state;
    w_ref_nxt   = r_ref;
    w_burst_nxt = r_burst;
    w_apply     = '0;
    w_fall0     = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      w_dly_nxt[i] = r_dly[i];
    end
    case (r_state)
      ST_IDLE: begin
        w_apply   = r_pend;
        w_ref_nxt = '0;
        for (int i = 0; i < CHANNELS; i++) begin
          w_cnt_nxt[i] = '0;
          w_dly_nxt[i] = '0;
        end
        if (mode_i == 2'b01) begin
          w_state_nxt = ST_RUN;
          w_ref_nxt   = '1;
          for (int i = 0; i < CHANNELS; i++) w_cnt_nxt[i] = w_h_eff[i] - CNT_W'(1);
        end else if (mode_i[1]) begin
          w_state_nxt = ST_ALIGN;
          w_burst_nxt = '0;
        end
      end
      ST_ALIGN: begin
        w_apply     = r_pend;
        w_state_nxt = ST_RUN;
        for (int i = 0; i < CHANNELS; i++) begin
          if (w_p_eff[i] == '0) begin
            w_ref_nxt[i] = 1'b1;
            w_cnt_nxt[i] = w_h_eff[i] - CNT_W'(1);
            w_dly_nxt[i] = '0;
          end else begin
            w_ref_nxt[i] = 1'b0;
            w_cnt_nxt[i] = '0;
            w_dly_nxt[i] = w_p_eff[i];
          end
        end
      end
      ST_RUN: begin
        if (mode_i == 2'b00) begin
          w_state_nxt = ST_IDLE;
          w_ref_nxt   = '0;
          for (int i = 0; i < CHANNELS; i++) begin
            w_cnt_nxt[i] = '0;
            w_dly_nxt[i] = '0;
          end
        end else if (w_realign) begin
          w_state_nxt = ST_ALIGN;
          w_ref_nxt   = '0;
          w_burst_nxt = '0;
        end else begin
          for (int i = 0; i < CHANNELS; i++) begin
            if (r_dly[i] != '0) begin
              w_dly_nxt[i] = r_dly[i] - CNT_W'(1);
              if (r_dly[i] == CNT_W'(1)) begin
                w_ref_nxt[i] = 1'b1;
                w_cnt_nxt[i] = r_h[i] - CNT_W'(1);
              end
            end else if (r_cnt[i] == '0) begin
              if (r_ref[i]) begin
                // Falling edge: pending config takes effect for the low half
                w_ref_nxt[i] = 1'b0;
                w_apply[i]   = r_pend[i];
                w_cnt_nxt[i] = w_h_eff[i] - CNT_W'(1);
              end else begin
                w_ref_nxt[i] = 1'b1;
                w_cnt_nxt[i] = r_h[i] - CNT_W'(1);
              end
            end else begin
              w_cnt_nxt[i] = r_cnt[i] - CNT_W'(1);
            end
          end
          w_fall0 = r_ref[0] & ~w_ref_nxt[0];
          if ((mode_i == 2'b11) && w_fall0) begin
            if (r_burst == BC_W'(BURST_EDGES - 1)) begin
              w_state_nxt = ST_DONE;
              w_ref_nxt   = '0;
            end else begin
              w_burst_nxt = r_burst + BC_W'(1);
            end
          end
        end
      end
      default: begin
        w_apply   = r_pend;
        w_ref_nxt = '0;
        if (mode_i == 2'b00) w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk100_i or negedge rst_pbn_i) begin
    if (!rst_pbn_i) begin
      r_state  <= ST_IDLE;
      r_mode_q <= 2'b00;
      r_ref    <= '0;
      r_sync   <= 1'b0;
      r_burst  <= '0;
      r_pend   <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        r_h[i]      <= CNT_W'(DEFAULT_HALF);
        r_p[i]      <= '0;
        r_pend_h[i] <= '0;
        r_pend_p[i] <= '0;
        r_cnt[i]    <= '0;
        r_dly[i]    <= '0;
      end
    end else begin
      r_state  <= w_state_nxt;
      r_mode_q <= mode_i;
      r_ref    <= w_ref_nxt;
      r_sync   <= w_ref_nxt[0] & ~r_ref[0];
      r_burst  <= w_burst_nxt;
      for (int i = 0; i < CHANNELS; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
        r_dly[i] <= w_dly_nxt[i];
        if (w_apply[i]) begin
          r_h[i]    <= r_pend_h[i];
          r_p[i]    <= r_pend_p[i];
          r_pend[i] <= 1'b0;
        end
        if (w_wr && (cfg_chan_i == CH_W'(i))) begin
          r_pend_h[i] <= w_half_in;
          r_pend_p[i] <= cfg_phase_i;
          r_pend[i]   <= 1'b1;
        end
      end
    end
  end

  assign cfg_ready_o = w_ready;
  assign ref_o       = r_ref;
  assign sync_o      = r_sync;
  assign busy_o      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ref_gen_array.sv
// tb/tb_ref_gen_array.sv - self-checking bench for ref_gen_array
// Event-time model: each channel holds the absolute cycle of its next level change.
module tb_ref_gen_array;
  localparam int NCH = 5;
  localparam int CW  = 12;
  localparam int DH  = 20;
  localparam int BE  = 3;
  localparam int CHW = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [1:0]     mode = 2'b00;
  logic           cfg_valid = 1'b0;
  logic [CHW-1:0] cfg_chan = '0;
  logic [CW-1:0]  cfg_half = '0;
  logic [CW-1:0]  cfg_phase = '0;
  logic           cfg_ready;
  logic [NCH-1:0] ref_o;
  logic           sync;
  logic           busy;

  ref_gen_array #(.CHANNELS(NCH), .CNT_W(CW), .DEFAULT_HALF(DH), .BURST_EDGES(BE)) dut (
    .clk100_i(clk), .rst_pbn_i(rst_n), .mode_i(mode), .cfg_valid_i(cfg_valid),
    .cfg_ready_o(cfg_ready), .cfg_chan_i(cfg_chan), .cfg_half_i(cfg_half),
    .cfg_phase_i(cfg_phase), .ref_o(ref_o), .sync_o(sync), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model
  int     m_state;
  int     m_h [NCH];
  int     m_p [NCH];
  int     m_ph [NCH];
  int     m_pp [NCH];
  bit     m_pend [NCH];
  bit     m_lvl [NCH];
  longint m_next [NCH];
  int     m_falls;
  int     m_prev;
  bit     m_sync;
  longint t = 0;

  function automatic bit model_ready();
    if (int'(cfg_chan) >= NCH) return 1'b1;
    return !m_pend[cfg_chan];
  endfunction

  task automatic apply(input int i);
    if (m_pend[i]) begin
      m_h[i] = m_ph[i];
      m_p[i] = m_pp[i];
      m_pend[i] = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_falls = 0; m_prev = 0; m_sync = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      m_h[i] = DH; m_p[i] = 0; m_pend[i] = 1'b0; m_lvl[i] = 1'b0; m_next[i] = 0;
    end
  endtask

  task automatic model_step();
    bit acc;
    bit old0;
    bit f0;
    int md;
    acc  = cfg_valid && model_ready();
    old0 = m_lvl[0];
    md   = int'(mode);
    t++;
    case (m_state)
      0: begin
        for (int i = 0; i < NCH; i++) apply(i);
        if (md == 1) begin
          m_state = 2;
          for (int i = 0; i < NCH; i++) begin m_lvl[i] = 1'b1; m_next[i] = t + m_h[i]; end
        end else if (md >= 2) begin
          m_state = 1; m_falls = 0;
        end
      end
      1: begin
        for (int i = 0; i < NCH; i++) begin
          apply(i);
          if (m_p[i] == 0) begin m_lvl[i] = 1'b1; m_next[i] = t + m_h[i]; end
          else begin m_lvl[i] = 1'b0; m_next[i] = t + m_p[i]; end
        end
        m_state = 2;
      end
      2: begin
        if (md == 0) begin
          m_state = 0;
          for (int i = 0; i < NCH; i++) m_lvl[i] = 1'b0;
        end else if ((md == 2 && m_prev != 2) || (md == 3 && m_prev != 3)) begin
          m_state = 1; m_falls = 0;
          for (int i = 0; i < NCH; i++) m_lvl[i] = 1'b0;
        end else begin
          f0 = 1'b0;
          for (int i = 0; i < NCH; i++) begin
            if (t == m_next[i]) begin
              if (m_lvl[i]) begin
                m_lvl[i] = 1'b0;
                if (i == 0) f0 = 1'b1;
                apply(i);
              end else begin
                m_lvl[i] = 1'b1;
              end
              m_next[i] = t + m_h[i];
            end
          end
          if (md == 3 && f0) begin
            m_falls++;
            if (m_falls == BE) begin
              m_state = 3;
              for (int i = 0; i < NCH; i++) m_lvl[i] = 1'b0;
            end
          end
        end
      end
      default: begin
        for (int i = 0; i < NCH; i++) apply(i);
        if (md == 0) m_state = 0;
      end
    endcase
    if (acc && int'(cfg_chan) < NCH) begin
      m_ph[cfg_chan] = (cfg_half == 0) ? 1 : int'(cfg_half);
      m_pp[cfg_chan] = int'(cfg_phase);
      m_pend[cfg_chan] = 1'b1;
    end
    m_sync = !old0 && m_lvl[0];
    m_prev = md;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      logic [7:0] exp;
      model_step();
      #1;
      for (int i = 0; i < NCH; i++) exp[i] = m_lvl[i];
      exp[5] = model_ready();
      exp[6] = (m_state != 0);
      exp[7] = m_sync;
      check("cycle", {24'd0, sync, busy, cfg_ready, ref_o}, {24'd0, exp});
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write(input int ch, input int h, input int p);
    int n;
    cfg_chan = CHW'(ch); cfg_half = CW'(h); cfg_phase = CW'(p); cfg_valid = 1'b1;
    n = 0;
    while (!cfg_ready && n < 100) begin step(1); n++; end
    check("wr_ready_timeout", n < 100, 1);
    step(1);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_level(input int ch, input bit lvl);
    int n;
    n = 0;
    while (ref_o[ch] != lvl && n < 300) begin step(1); n++; end
    check("wait_level_timeout", n < 300, 1);
  endtask

  task automatic measure_level(input int ch, input bit lvl, output int n);
    n = 0;
    while (ref_o[ch] == lvl && n < 200) begin step(1); n++; end
  endtask

  initial begin
    int n;
    int n_r;
    int n_s;
    bit prev0;

    step(3);
    check("rst_ref", ref_o, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", cfg_ready, 1);
    rst_n = 1'b1;
    step(2);

    mode = 2'b01;
    step(1);
    check("fr_rise", ref_o, 5'h1f);
    check("fr_sync", sync, 1);
    n = 0;
    do begin step(1); n++; end while (!sync && n < 200);
    check("fr_sync_period", n, 40);
    step(7);

    write(2, 5, 0);
    check("rc_ready_low", cfg_ready, 0);
    wait_level(2, 1);
    wait_level(2, 0);
    check("rc_ready_back", cfg_ready, 1);
    measure_level(2, 0, n);
    check("rc_low_half", n, 5);
    measure_level(2, 1, n);
    check("rc_high_half", n, 5);
    step(15);

    write(0, 20, 0);
    write(1, 20, 3);
    write(2, 20, 7);
    write(3, 20, 12);
    mode = 2'b10;
    step(1);
    check("al_E", ref_o, 0);
    check("al_busy", busy, 1);
    step(1);
    check("al_E1", ref_o, 5'h11);
    step(3);
    check("al_E4", ref_o, 5'h13);
    step(4);
    check("al_E8", ref_o, 5'h17);
    step(5);
    check("al_E13", ref_o, 5'h1f);
    step(30);
    mode = 2'b01;
    step(30);
    mode = 2'b10;
    step(1);
    check("ra_E", ref_o, 0);
    step(1);
    check("ra_E1", ref_o, 5'h11);
    step(20);

    mode = 2'b00;
    step(2);
    write(0, 4, 0);
    step(1);
    mode = 2'b11;
    n_r = 0; n_s = 0; prev0 = ref_o[0];
    repeat (40) begin
      step(1);
      if (!prev0 && ref_o[0]) n_r++;
      if (sync) n_s++;
      prev0 = ref_o[0];
    end
    check("burst_rises", n_r, 3);
    check("burst_syncs", n_s, 3);
    check("burst_done_ref", ref_o, 0);
    check("burst_done_busy", busy, 1);
    mode = 2'b00;
    step(1);
    check("burst_idle_busy", busy, 0);

    write(1, 0, 0);
    step(1);
    mode = 2'b01;
    step(3);
    wait_level(1, 1);
    measure_level(1, 1, n);
    check("h0_high", n, 1);
    measure_level(1, 0, n);
    check("h0_low", n, 1);
    cfg_chan = 3'd5;
    step(1);
    check("oor_ready", cfg_ready, 1);
    write(5, 7, 7);
    wait_level(0, 1);
    wait_level(0, 0);
    measure_level(0, 0, n);
    check("oor_ch0_low", n, 4);

    mode = 2'b00;
    step(2);
    mode = 2'b11;
    step(10);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("ar_ref", ref_o, 0);
    check("ar_sync", sync, 0);
    check("ar_busy", busy, 0);
    mode = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    step(2);
    mode = 2'b01;
    step(1);
    measure_level(0, 1, n);
    check("ar_default_half", n, 20);
    step(5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
